// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter that shares one FIFO write port among NREQ producers.
// A grant is held until the grantee's last beat is accepted or MAX_BURST beats have been written.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wr_data,
  output logic                  fifo_wr_valid,
  input  logic                  fifo_wr_ready,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [GW-1:0] pick;
  logic          found;
  logic [GW:0]   scan;
  logic          accept;
  logic          release_burst;

  // Scan last_grant+1, last_grant+2, ... modulo NREQ; the first valid requester wins.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    scan  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = {1'b0, last_q} + (GW+1)'(k);
      if (scan >= (GW+1)'(NREQ)) begin
        scan = scan - (GW+1)'(NREQ);
      end
      if (!found && req_valid[scan[GW-1:0]]) begin
        found = 1'b1;
        pick  = scan[GW-1:0];
      end
    end
  end

  always_comb begin
    fifo_wr_data = req_data[DSIZE-1:0];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        fifo_wr_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign busy     = (state_q == StBusy);
  assign grant_id = grant_q;

  // Handshake is suppressed during reset so an aborted burst accepts no further beat.
  assign fifo_wr_valid = busy && !rst && req_valid[grant_q];

  always_comb begin
    req_ready = '0;
    if (busy && !rst) begin
      req_ready[grant_q] = fifo_wr_ready;
    end
  end

  assign accept        = fifo_wr_valid && fifo_wr_ready;
  assign release_burst = accept && (req_last[grant_q] || (cnt_q == 8'(MAX_BURST - 1)));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (release_burst) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (accept) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: arbitration order, burst locking, forced release,
// back-pressure, valid gaps and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DSIZE = 32;

  logic                  clk;
  logic                  rst;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wr_data;
  logic                  fifo_wr_valid;
  logic                  fifo_wr_ready;
  logic                  busy;
  logic [1:0]            grant_id;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .DSIZE    (DSIZE),
    .MAX_BURST(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_valid(fifo_wr_valid),
    .fifo_wr_ready(fifo_wr_ready),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for combinational outputs to settle after input changes, then compares them.
  task automatic expect_out(input string tag, input logic eb, input logic [1:0] eg,
                            input logic ev, input logic [31:0] ed, input logic [3:0] er);
    #1;
    chk({tag, ".busy"}, 64'(busy), 64'(eb));
    chk({tag, ".grant"}, 64'(grant_id), 64'(eg));
    chk({tag, ".valid"}, 64'(fifo_wr_valid), 64'(ev));
    chk({tag, ".ready"}, 64'(req_ready), 64'(er));
    if (ev) chk({tag, ".data"}, 64'(fifo_wr_data), 64'(ed));
  endtask

  task automatic set_beat(input int i, input logic [31:0] d, input logic l);
    req_data[i*DSIZE +: DSIZE] = d;
    req_last[i] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // Producer rule: a stalled valid beat must keep its data and last flag.
  initial begin
    logic [NREQ-1:0]       hold = '0;
    logic [NREQ*DSIZE-1:0] pdata = '0;
    logic [NREQ-1:0]       plast = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (hold[i] && req_valid[i]) begin
          checks++;
          assert (req_data[i*DSIZE +: DSIZE] === pdata[i*DSIZE +: DSIZE] &&
                  req_last[i] === plast[i]) else begin
            failures++;
            $error("FAIL producer_rule req=%0d observed=%0h expected=%0h", i,
                   req_data[i*DSIZE +: DSIZE], pdata[i*DSIZE +: DSIZE]);
          end
        end
      end
      hold  = req_valid & ~req_ready;
      pdata = req_data;
      plast = req_last;
    end
  end

  initial begin
    logic [1:0] g;
    logic [3:0] er;

    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_wr_ready = 1'b0;
    tick();
    tick();
    expect_out("reset", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

    // 1: requester 0 three-beat burst, then requester 2 after one idle cycle
    rst = 1'b0;
    req_valid = 4'b0101;
    set_beat(0, 32'hA0, 1'b0);
    set_beat(2, 32'hC0, 1'b1);
    fifo_wr_ready = 1'b1;
    expect_out("t1.idle", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("t1.a0", 1'b1, 2'd0, 1'b1, 32'hA0, 4'b0001);
    tick();
    set_beat(0, 32'hA1, 1'b0);
    expect_out("t1.a1", 1'b1, 2'd0, 1'b1, 32'hA1, 4'b0001);
    tick();
    set_beat(0, 32'hA2, 1'b1);
    expect_out("t1.a2", 1'b1, 2'd0, 1'b1, 32'hA2, 4'b0001);
    tick();
    req_valid = 4'b0100;
    expect_out("t1.bubble", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("t1.c0", 1'b1, 2'd2, 1'b1, 32'hC0, 4'b0100);
    tick();
    req_valid = '0;
    expect_out("t1.end", 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);

    // 2: all requesters with single-beat bursts rotate 0,1,2,3,0,1
    do_reset();
    for (int i = 0; i < 4; i++) set_beat(i, 32'h10 + i, 1'b1);
    req_valid = 4'b1111;
    expect_out("t2.idle", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      g = 2'(k % 4);
      er = 4'b0001 << g;
      tick();
      expect_out("t2.grant", 1'b1, g, 1'b1, 32'h10 + 32'(g), er);
      tick();
      expect_out("t2.bubble", 1'b0, g, 1'b0, 32'h0, 4'b0000);
    end
    req_valid = '0;

    // 3: 20-beat burst from requester 1 is split at 16; requester 3 goes in between
    do_reset();
    req_valid = 4'b0010;
    set_beat(1, 32'h101, 1'b0);
    expect_out("t3.idle", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    tick();
    req_valid[3] = 1'b1;
    set_beat(3, 32'h300, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      set_beat(1, 32'h100 + n, 1'b0);
      expect_out("t3.beat", 1'b1, 2'd1, 1'b1, 32'h100 + n, 4'b0010);
      if (n == 16) chk("t3.cnt", 64'(dut.cnt_q), 64'd15);
      tick();
    end
    set_beat(1, 32'h111, 1'b0);
    expect_out("t3.forced", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("t3.g3", 1'b1, 2'd3, 1'b1, 32'h300, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    expect_out("t3.bubble", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
    tick();
    for (int n = 17; n <= 20; n++) begin
      set_beat(1, 32'h100 + n, n == 20);
      expect_out("t3.resume", 1'b1, 2'd1, 1'b1, 32'h100 + n, 4'b0010);
      tick();
    end
    req_valid = '0;
    expect_out("t3.end", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);

    // 4: FIFO full for 5 cycles after 4 accepted beats
    req_valid = 4'b0100;
    set_beat(2, 32'h201, 1'b0);
    expect_out("t4.idle", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);
    tick();
    for (int n = 1; n <= 4; n++) begin
      set_beat(2, 32'h200 + n, 1'b0);
      expect_out("t4.beat", 1'b1, 2'd2, 1'b1, 32'h200 + n, 4'b0100);
      tick();
    end
    fifo_wr_ready = 1'b0;
    set_beat(2, 32'h205, 1'b0);
    for (int s = 0; s < 5; s++) begin
      expect_out("t4.stall", 1'b1, 2'd2, 1'b1, 32'h205, 4'b0000);
      chk("t4.cnt", 64'(dut.cnt_q), 64'd4);
      tick();
    end
    fifo_wr_ready = 1'b1;
    for (int n = 5; n <= 8; n++) begin
      set_beat(2, 32'h200 + n, n == 8);
      expect_out("t4.resume", 1'b1, 2'd2, 1'b1, 32'h200 + n, 4'b0100);
      tick();
    end
    req_valid = '0;
    expect_out("t4.end", 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);

    // 5: grantee drops valid for 3 cycles while requester 0 waits
    req_valid = 4'b1001;
    set_beat(3, 32'h301, 1'b0);
    set_beat(0, 32'h0F0, 1'b1);
    expect_out("t5.idle", 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);
    tick();
    for (int n = 1; n <= 2; n++) begin
      set_beat(3, 32'h300 + n, 1'b0);
      expect_out("t5.beat", 1'b1, 2'd3, 1'b1, 32'h300 + n, 4'b1000);
      tick();
    end
    req_valid[3] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      expect_out("t5.gap", 1'b1, 2'd3, 1'b0, 32'h0, 4'b1000);
      tick();
    end
    req_valid[3] = 1'b1;
    for (int n = 3; n <= 4; n++) begin
      set_beat(3, 32'h300 + n, n == 4);
      expect_out("t5.resume", 1'b1, 2'd3, 1'b1, 32'h300 + n, 4'b1000);
      tick();
    end
    req_valid = 4'b0001;
    expect_out("t5.bubble", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("t5.g0", 1'b1, 2'd0, 1'b1, 32'h0F0, 4'b0001);
    tick();
    req_valid = '0;
    expect_out("t5.end", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

    // 6: reset at beat 2 of requester 2's burst; requester 0 wins afterwards
    req_valid = 4'b0101;
    set_beat(2, 32'h201, 1'b0);
    expect_out("t6.idle", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    tick();
    expect_out("t6.b1", 1'b1, 2'd2, 1'b1, 32'h201, 4'b0100);
    tick();
    set_beat(2, 32'h202, 1'b0);
    rst = 1'b1;
    expect_out("t6.rstcyc", 1'b1, 2'd2, 1'b0, 32'h0, 4'b0000);
    tick();
    rst = 1'b0;
    expect_out("t6.post", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
    chk("t6.last", 64'(dut.last_q), 64'd3);
    tick();
    expect_out("t6.g0", 1'b1, 2'd0, 1'b1, 32'h0F0, 4'b0001);
    tick();
    req_valid = '0;
    expect_out("t6.end", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, burst-locking arbiter that shares one FIFO write port among NREQ independent producers (pattern engine, host bridge, test generator, etc.). Each producer offers beats with valid/ready/last. The arbiter grants one producer at a time and holds the grant until that producer's burst ends, so bursts are never interleaved in the FIFO. It sits between the producers and the write side of the LED-data FIFO.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 32, data width per beat
MAX_BURST, 16, maximum beats per grant before forced release (1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_data  input  NREQ*DSIZE  packed beat data; requester i occupies bits [i*DSIZE +: DSIZE]
req_valid  input  NREQ  beat valid per requester
req_last  input  NREQ  last beat of the burst, per requester; qualified by req_valid
req_ready  output  NREQ  beat accepted per requester
fifo_wr_data  output  DSIZE  data to the FIFO write port
fifo_wr_valid  output  1  write valid to the FIFO
fifo_wr_ready  input  1  FIFO not full
busy  output  1  a grant is active (state BUSY)
grant_id  output  $clog2(NREQ), min 1  index of the current or most recent grantee

Behaviour:
- Reset: all state updates happen on the rising edge of clk while rst=1.
  - state=IDLE, last_grant=NREQ-1, so requester 0 has first priority.
  - beat_cnt=0, grant_id=0.
  - Outputs: busy=0, fifo_wr_valid=0, req_ready=0.
  - fifo_wr_data is don't-care but must be driven (mux output).
- Reset asserted mid-burst aborts the burst. No beat is accepted in the reset cycle, and any partial burst already in the FIFO is left as is.
- Beat accept: a beat is accepted when fifo_wr_valid and fifo_wr_ready are both 1 in the same cycle.
- State IDLE:
  - fifo_wr_valid=0, all req_ready=0.
  - If any req_valid=1, choose the first requester with req_valid=1 scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - Register that choice as grant_id, clear beat_cnt, go to BUSY.
  - If no req_valid is set, stay in IDLE.
- State BUSY (g=grant_id):
  - busy=1.
  - fifo_wr_valid = req_valid[g], fifo_wr_data = req_data[g]; both are combinational passthrough (zero added latency).
  - req_ready[g] = fifo_wr_ready. All other req_ready bits are 0.
  - On an accepted beat: beat_cnt increments.
  - Release condition: an accepted beat with req_last[g]=1, or an accepted beat with beat_cnt=MAX_BURST-1.
  - On release: last_grant<=g, go to IDLE.
  - Between grants there is one IDLE cycle (arbitration bubble).
  - If req_valid[g] drops mid-burst, the grant is held. fifo_wr_valid=0 and no timeout applies.
  - If fifo_wr_ready=0 (FIFO full), the beat stalls. The arbiter holds grant and beat_cnt unchanged.
- Forced release at MAX_BURST does not modify data. The producer's remaining beats form a new burst on its next grant.
- grant_id keeps its value after release until the next grant.
- beat_cnt is 8 bits wide and never exceeds MAX_BURST-1.
- Requests arriving during BUSY are only considered at the next IDLE cycle.
- A requester must not change req_data/req_last while req_valid=1 and req_ready=0 (producer rule). The bench checks this as an assertion.

Test Plan:
1. Reset release with req_valid=4'b0101, requester 0 offering 3 beats 0xA0..0xA2 (last on 0xA2), fifo_wr_ready=1 -> grant_id=0 one cycle after the request, FIFO receives 0xA0, 0xA1, 0xA2 on consecutive cycles, then IDLE for 1 cycle, then grant_id=2.
2. Requesters 0..3 all continuously valid with 1-beat bursts -> grant order 0,1,2,3,0,1 with exactly one idle cycle between grants.
3. Requester 1 offers a 20-beat burst with MAX_BURST=16 -> release after beat 16. If requester 3 is valid it is served next; requester 1 resumes later with beats 17..20.
4. fifo_wr_ready=0 for 5 cycles mid-burst at beat 4 -> no req_ready pulses, beat_cnt stays at 4, grant is held, the burst resumes without loss or duplication.
5. req_valid[g] drops for 3 cycles mid-burst while another requester is valid -> grant is not switched, fifo_wr_valid=0 for those 3 cycles, no beats from other requesters enter the FIFO.
6. rst=1 for 1 cycle at beat 2 of requester 2's burst -> next cycle busy=0, req_ready=0, last_grant=NREQ-1, and requester 0 wins the next arbitration if valid.
